// File: rtl/hc194_seq_ctrl_if.sv
// Command channel for hc194_seq_ctrl: valid/ready handshake plus command fields.
interface hc194_seq_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [0:3]       cmd_data;
  logic             cmd_dir;
  logic             cmd_rot;
  logic             cmd_ser;
  logic [CNT_W-1:0] cmd_cnt;
  logic             cmd_abort;

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_rot, cmd_ser, cmd_cnt, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_rot, cmd_ser, cmd_cnt, cmd_abort,
    output cmd_ready
  );
endinterface

// File: rtl/hc194_seq_ctrl.sv
// Command sequencer for one external HC194 4-bit universal shift register.
// Loads a word, shifts it left/right N times (fill or rotate), then returns Q.
module hc194_seq_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic                   CP,
  input  logic                   MR,
  hc194_seq_ctrl_if.slave        cmd,
  output logic [1:0]             S,
  output logic [0:3]             D,
  output logic                   DSR,
  output logic                   DSL,
  input  logic [0:3]             Q,
  output logic                   busy,
  output logic                   done,
  output logic [0:3]             result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] cnt_l;
  logic [0:3]       data_l;
  logic             dir_l;
  logic             rot_l;
  logic             ser_l;
  logic             ready_q;
  logic             shift_en;

  assign cmd.cmd_ready = ready_q;

  // Sequencer FSM; S, D, busy and ready are registered alongside the state
  // so they always equal the decode of the state they accompany.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state     <= IDLE;
      remaining <= '0;
      cnt_l     <= '0;
      data_l    <= '0;
      dir_l     <= 1'b0;
      rot_l     <= 1'b0;
      ser_l     <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      S         <= 2'b00;
      D         <= '0;
      busy      <= 1'b0;
      ready_q   <= 1'b1;
      shift_en  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && cmd.cmd_abort) begin
        state    <= IDLE;
        S        <= 2'b00;
        D        <= '0;
        busy     <= 1'b0;
        ready_q  <= 1'b1;
        shift_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd.cmd_valid && ready_q) begin
              data_l  <= cmd.cmd_data;
              dir_l   <= cmd.cmd_dir;
              rot_l   <= cmd.cmd_rot;
              ser_l   <= cmd.cmd_ser;
              cnt_l   <= cmd.cmd_cnt;
              state   <= LOAD;
              S       <= 2'b11;
              D       <= cmd.cmd_data;
              busy    <= 1'b1;
              ready_q <= 1'b0;
            end
          end
          LOAD: begin
            remaining <= cnt_l;
            D         <= '0;
            if (cnt_l == '0) begin
              state <= DONE;
              S     <= 2'b00;
            end else begin
              state    <= SHIFT;
              S        <= dir_l ? 2'b10 : 2'b01;
              shift_en <= 1'b1;
            end
          end
          SHIFT: begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state    <= DONE;
              S        <= 2'b00;
              shift_en <= 1'b0;
            end
          end
          DONE: begin
            result  <= Q;
            done    <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            ready_q <= 1'b1;
          end
          default: begin
            state    <= IDLE;
            S        <= 2'b00;
            D        <= '0;
            busy     <= 1'b0;
            ready_q  <= 1'b1;
            shift_en <= 1'b0;
          end
        endcase
      end
    end
  end

  // Serial inputs: rotate feeds back the outgoing end bit, otherwise the fill bit.
  always_comb begin
    DSR = 1'b0;
    DSL = 1'b0;
    if (shift_en) begin
      if (rot_l) begin
        DSR = Q[3];
        DSL = Q[0];
      end else begin
        DSR = ser_l;
        DSL = ser_l;
      end
    end
  end

endmodule

// File: tb/tb_hc194_seq_ctrl.sv
// Self-checking bench for hc194_seq_ctrl with a behavioural HC194 attached.
module tb_hc194_seq_ctrl;
  localparam int CNT_W = 3;

  logic       CP = 1'b0;
  logic       MR = 1'b0;
  logic [1:0] S;
  logic [0:3] D;
  logic [0:3] Q;
  logic [0:3] result;
  logic       DSR, DSL, busy, done;

  int total = 0;
  int bad   = 0;
  logic [0:3] last_result = 4'b0000;

  hc194_seq_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

  hc194_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .CP(CP), .MR(MR), .cmd(cmd_if),
    .S(S), .D(D), .DSR(DSR), .DSL(DSL), .Q(Q),
    .busy(busy), .done(done), .result(result)
  );

  always #5 CP = ~CP;

  // External HC194 sharing CP and MR with the controller.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) Q <= 4'b0000;
    else begin
      case (S)
        2'b01:   Q <= {DSR, Q[0:2]};
        2'b10:   Q <= {Q[1:3], DSL};
        2'b11:   Q <= D;
        default: Q <= Q;
      endcase
    end
  end

  // Reference: the word as a number with Q0 weighted 8; right = /2 with a bit
  // entering at weight 8, left = *2 mod 16 with a bit entering at weight 1.
  function automatic logic [0:3] ref_shift(input logic [0:3] data, input logic dir,
                                           input logic rot, input logic ser, input int n);
    int v;
    v = int'(data);
    for (int i = 0; i < n; i++) begin
      int fill;
      if (!dir) begin
        fill = rot ? (v % 2) : int'(ser);
        v = (v / 2) + fill * 8;
      end else begin
        fill = rot ? (v / 8) : int'(ser);
        v = ((v * 2) % 16) + fill;
      end
    end
    return 4'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_S"},      32'(S), 32'(2'b00));
    chk({tag, "_D"},      32'(D), 32'(4'b0000));
    chk({tag, "_DSR"},    32'(DSR), 32'(1'b0));
    chk({tag, "_DSL"},    32'(DSL), 32'(1'b0));
    chk({tag, "_busy"},   32'(busy), 32'(1'b0));
    chk({tag, "_ready"},  32'(cmd_if.cmd_ready), 32'(1'b1));
    chk({tag, "_done"},   32'(done), 32'(1'b0));
    chk({tag, "_result"}, 32'(result), 32'(4'b0000));
    chk({tag, "_Q"},      32'(Q), 32'(4'b0000));
  endtask

  task automatic set_fields(input logic [0:3] data, input logic dir, input logic rot,
                            input logic ser, input logic [2:0] cnt);
    cmd_if.cmd_data = data;
    cmd_if.cmd_dir  = dir;
    cmd_if.cmd_rot  = rot;
    cmd_if.cmd_ser  = ser;
    cmd_if.cmd_cnt  = cnt;
  endtask

  // One full command from idle, checking pins every cycle and the final result.
  task automatic run_cmd(input logic [0:3] data, input logic dir, input logic rot,
                         input logic ser, input logic [2:0] cnt, input logic abort_idle,
                         input logic [0:3] req_res);
    int  k;
    int  busy_cnt = 0;
    int  load_cnt = 0;
    int  sh_cnt   = 0;
    bit  seen     = 0;
    logic [1:0] sh_code;
    sh_code = dir ? 2'b10 : 2'b01;
    chk("ready_idle", 32'(cmd_if.cmd_ready), 32'(1'b1));
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_abort = abort_idle;
    set_fields(data, dir, rot, ser, cnt);
    step();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_abort = 1'b0;
    set_fields(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
    chk("accept_busy", 32'(busy), 32'(1'b1));
    for (k = 0; k <= int'(cnt) + 4; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      busy_cnt += int'(busy);
      if (S == 2'b11) begin
        load_cnt++;
        chk("load_D", 32'(D), 32'(data));
      end else begin
        chk("D_zero", 32'(D), 32'(4'b0000));
      end
      if (S == sh_code) begin
        sh_cnt++;
        chk("DSR", 32'(DSR), 32'(rot ? Q[3] : ser));
        chk("DSL", 32'(DSL), 32'(rot ? Q[0] : ser));
      end else begin
        chk("serial_idle", 32'({DSR, DSL}), 32'(2'b00));
      end
      if (k >= 1) chk("q_track", 32'(Q), 32'(ref_shift(data, dir, rot, ser, k - 1)));
      step();
    end
    chk("done_seen", 32'(seen), 32'(1'b1));
    chk("latency", 32'(k), 32'(int'(cnt) + 2));
    chk("result", 32'(result), 32'(req_res));
    chk("busy_cycles", 32'(busy_cnt), 32'(int'(cnt) + 2));
    chk("load_cycles", 32'(load_cnt), 32'(1));
    chk("shift_cycles", 32'(sh_cnt), 32'(cnt));
    last_result = req_res;
    step();
    chk("done_pulse", 32'(done), 32'(1'b0));
    chk("result_hold", 32'(result), 32'(last_result));
  endtask

  typedef struct {
    logic [0:3] data;
    logic       dir;
    logic       rot;
    logic       ser;
    logic [2:0] cnt;
    logic [0:3] res;
  } vec_t;

  vec_t vt[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    logic [0:3] prev;
    logic [0:3] qa;
    logic [0:3] d;
    logic dr, ro, se;
    logic [2:0] c;

    vt[0] = '{4'b1011, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1011};
    vt[1] = '{4'b1011, 1'b0, 1'b0, 1'b0, 3'd2, 4'b0010};
    vt[2] = '{4'b1000, 1'b1, 1'b1, 1'b0, 3'd1, 4'b0001};
    vt[3] = '{4'b1000, 1'b1, 1'b1, 1'b0, 3'd4, 4'b1000};
    vt[4] = '{4'b1100, 1'b0, 1'b1, 1'b0, 3'd7, 4'b1001};
    vt[5] = '{4'b0110, 1'b1, 1'b0, 1'b1, 3'd3, 4'b0111};
    vt[6] = '{4'b0001, 1'b0, 1'b0, 1'b1, 3'd5, 4'b1111};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_abort = 1'b0;
    set_fields(4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
    MR = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge CP);
    MR = 1'b1;
    step();

    // Directed table
    foreach (vt[i]) run_cmd(vt[i].data, vt[i].dir, vt[i].rot, vt[i].ser, vt[i].cnt, 1'b0, vt[i].res);

    // Back-to-back with cmd_valid held; second command offered while busy.
    cmd_if.cmd_valid = 1'b1;
    set_fields(4'b0110, 1'b1, 1'b1, 1'b0, 3'd1);
    step();
    chk("b2b_accept_a", 32'(busy), 32'(1'b1));
    set_fields(4'b1001, 1'b0, 1'b0, 1'b1, 3'd2);
    seen = 0;
    for (k = 0; k < 10; k++) begin
      if (done) begin seen = 1; break; end
      chk("b2b_ready_busy", 32'(cmd_if.cmd_ready), 32'(1'b0));
      step();
    end
    chk("b2b_done_a", 32'(seen), 32'(1'b1));
    chk("b2b_result_a", 32'(result), 32'(4'b1100));
    chk("b2b_ready_done", 32'(cmd_if.cmd_ready), 32'(1'b1));
    step();
    cmd_if.cmd_valid = 1'b0;
    chk("b2b_load_b_S", 32'(S), 32'(2'b11));
    chk("b2b_load_b_D", 32'(D), 32'(4'b1001));
    seen = 0;
    for (k = 0; k < 10; k++) begin
      if (done) begin seen = 1; break; end
      step();
    end
    chk("b2b_done_b", 32'(seen), 32'(1'b1));
    chk("b2b_latency_b", 32'(k), 32'(4));
    chk("b2b_result_b", 32'(result), 32'(4'b1110));
    last_result = 4'b1110;
    step();

    // Abort at the second SHIFT cycle
    prev = last_result;
    cmd_if.cmd_valid = 1'b1;
    set_fields(4'b1011, 1'b0, 1'b1, 1'b0, 3'd5);
    step();
    cmd_if.cmd_valid = 1'b0;
    step();
    chk("abort_shift1_S", 32'(S), 32'(2'b01));
    step();
    chk("abort_shift2_S", 32'(S), 32'(2'b01));
    cmd_if.cmd_abort = 1'b1;
    step();
    cmd_if.cmd_abort = 1'b0;
    chk("abort_S", 32'(S), 32'(2'b00));
    chk("abort_busy", 32'(busy), 32'(1'b0));
    chk("abort_ready", 32'(cmd_if.cmd_ready), 32'(1'b1));
    chk("abort_done", 32'(done), 32'(1'b0));
    chk("abort_result", 32'(result), 32'(prev));
    chk("abort_Q", 32'(Q), 32'(4'b1110));
    qa = Q;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_done", 32'(done), 32'(1'b0));
      chk("abort_Q_hold", 32'(Q), 32'(qa));
      chk("abort_hold_S", 32'(S), 32'(2'b00));
    end

    // Abort in IDLE must not block an accept
    run_cmd(4'b0101, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 4'b0100);

    // Reset mid-SHIFT
    cmd_if.cmd_valid = 1'b1;
    set_fields(4'b0111, 1'b1, 1'b0, 1'b1, 3'd5);
    step();
    cmd_if.cmd_valid = 1'b0;
    step();
    step();
    chk("mr_pre_S", 32'(S), 32'(2'b10));
    MR = 1'b0;
    #1;
    chk_reset("mr_mid");
    @(negedge CP);
    MR = 1'b1;
    last_result = 4'b0000;
    step();
    chk("mr_after_done", 32'(done), 32'(1'b0));
    chk("mr_after_ready", 32'(cmd_if.cmd_ready), 32'(1'b1));

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      d  = 4'($urandom);
      dr = 1'($urandom);
      ro = 1'($urandom);
      se = 1'($urandom);
      c  = 3'($urandom_range(0, 7));
      run_cmd(d, dr, ro, se, c, 1'($urandom_range(0, 3) == 0),
              ref_shift(d, dr, ro, se, int'(c)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
